// File: rtl/t07_ext_mem_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the external memory arbiter and the
// wishbone manager it drives.
interface t07_ext_mem_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_instr;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        err;
    logic [1:0]  rwi_out;
    logic [31:0] addr_out;
    logic [31:0] wdata_out;
    logic        busy_o;
    logic [31:0] rdata_in;

    modport master (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
        input  busy_o, rdata_in,
        output fetch_ack, fetch_instr, data_ack, data_rdata, err,
        output rwi_out, addr_out, wdata_out
    );

    modport slave (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
        output busy_o, rdata_in,
        input  fetch_ack, fetch_instr, data_ack, data_rdata, err,
        input  rwi_out, addr_out, wdata_out
    );
endinterface

// File: rtl/t07_ext_mem_arbiter.sv
// Shares one external memory port between instruction fetch and data load/store:
// arbitration with a data-streak limit, busy handshake, one-cycle ack and timeout abort.
module t07_ext_mem_arbiter #(
    parameter logic [7:0] ADDR_PREFIX     = 8'h33,
    parameter int         MAX_DATA_STREAK = 4,
    parameter int         TIMEOUT         = 64
) (
    input logic                   clk,
    input logic                   nRst,
    t07_ext_mem_arbiter_if.master bus
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [1:0]    RWI_READ   = 2'b10;
    localparam logic [1:0]    RWI_WRITE  = 2'b01;
    localparam logic [1:0]    RWI_IDLE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic          grant_s;
    logic          grant_data_s;
    logic          complete_s;
    logic          abort_s;
    logic          tmo_hit_s;
    logic [1:0]    cmd_s;
    logic          owner_data_r;
    logic          we_r;
    logic [SW-1:0] streak_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [1:0]    rwi_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          fetch_ack_r;
    logic          data_ack_r;
    logic          err_r;
    logic [31:0]   fetch_instr_r;
    logic [31:0]   data_rdata_r;

    // Next-state decode: arbitration in IDLE, handshake progress and timeout abort elsewhere.
    always_comb begin
        state_nx_s   = state_r;
        grant_s      = 1'b0;
        grant_data_s = 1'b0;
        complete_s   = 1'b0;
        abort_s      = 1'b0;
        tmo_hit_s    = (tmo_cnt_r == TMO_LAST);
        case (state_r)
            ST_IDLE: begin
                if (bus.data_req && bus.fetch_req) begin
                    grant_s      = 1'b1;
                    grant_data_s = (streak_r != STREAK_MAX);
                end else if (bus.data_req) begin
                    grant_s      = 1'b1;
                    grant_data_s = 1'b1;
                end else if (bus.fetch_req) begin
                    grant_s      = 1'b1;
                    grant_data_s = 1'b0;
                end else begin
                    grant_s      = 1'b0;
                    grant_data_s = 1'b0;
                end
                if (grant_s) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (tmo_hit_s) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_DONE;
                end else if (bus.busy_o) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A completion seen on the last allowed cycle still counts as a completion.
                if (!bus.busy_o) begin
                    complete_s = 1'b1;
                    state_nx_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        if (grant_data_s && bus.data_we) begin
            cmd_s = RWI_WRITE;
        end else begin
            cmd_s = RWI_READ;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Data-streak counter: counts data grants that made a pending fetch wait.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_s) begin
            if (!grant_data_s || !bus.fetch_req) begin
                streak_r <= {SW{1'b0}};
            end else if (streak_r != STREAK_MAX) begin
                streak_r <= streak_r + SW'(1);
            end
        end
    end

    // Timeout counter, restarted on every grant and running while the access is outstanding.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (grant_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end

    // Request latch plus registered wishbone command and completion outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            owner_data_r  <= 1'b0;
            we_r          <= 1'b0;
            rwi_r         <= RWI_IDLE;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            fetch_ack_r   <= 1'b0;
            data_ack_r    <= 1'b0;
            err_r         <= 1'b0;
            fetch_instr_r <= 32'd0;
            data_rdata_r  <= 32'd0;
        end else begin
            fetch_ack_r <= 1'b0;
            data_ack_r  <= 1'b0;
            err_r       <= 1'b0;
            if (grant_s) begin
                owner_data_r <= grant_data_s;
                we_r         <= grant_data_s & bus.data_we;
                rwi_r        <= cmd_s;
                addr_r       <= {ADDR_PREFIX,
                                 grant_data_s ? bus.data_addr[23:0] : bus.fetch_addr[23:0]};
                wdata_r      <= bus.data_wdata;
            end else if (abort_s) begin
                rwi_r <= RWI_IDLE;
                err_r <= 1'b1;
                if (owner_data_r) begin
                    data_ack_r   <= 1'b1;
                    data_rdata_r <= 32'd0;
                end else begin
                    fetch_ack_r   <= 1'b1;
                    fetch_instr_r <= 32'd0;
                end
            end else if (complete_s) begin
                if (owner_data_r) begin
                    data_ack_r   <= 1'b1;
                    data_rdata_r <= we_r ? 32'd0 : bus.rdata_in;
                end else begin
                    fetch_ack_r   <= 1'b1;
                    fetch_instr_r <= bus.rdata_in;
                end
            end else if ((state_r == ST_ISSUE) && bus.busy_o) begin
                rwi_r <= RWI_IDLE;
            end
        end
    end

    assign bus.rwi_out     = rwi_r;
    assign bus.addr_out    = addr_r;
    assign bus.wdata_out   = wdata_r;
    assign bus.fetch_ack   = fetch_ack_r;
    assign bus.data_ack    = data_ack_r;
    assign bus.err         = err_r;
    assign bus.fetch_instr = fetch_instr_r;
    assign bus.data_rdata  = data_rdata_r;
endmodule

// File: tb/tb_t07_ext_mem_arbiter.sv
// Scoreboard bench for the external memory arbiter: directed requests, a wishbone
// responder model and an ack monitor that checks against queued expectations.
module tb_t07_ext_mem_arbiter;
    logic clk  = 1'b0;
    logic nRst = 1'b1;

    t07_ext_mem_arbiter_if ifc ();

    t07_ext_mem_arbiter #(
        .ADDR_PREFIX    (8'h33),
        .MAX_DATA_STREAK(4),
        .TIMEOUT        (64)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic [31:0] data;
        logic        err;
    } ack_exp_t;

    typedef struct {
        logic [1:0]  rwi;
        logic [31:0] addr;
        logic        chk_wd;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } bus_exp_t;

    ack_exp_t ack_q[$];
    bus_exp_t bus_q[$];
    int   n_vec        = 0;
    int   n_miss       = 0;
    int   cyc          = 0;
    int   last_ack_cyc = 0;
    logic bus_dead     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input logic is_data, input logic [31:0] d, input logic e);
        ack_exp_t a;
        a.is_data = is_data;
        a.data    = d;
        a.err     = e;
        ack_q.push_back(a);
    endtask

    task automatic exp_bus(input logic [1:0] rwi, input logic [31:0] addr, input logic chk_wd,
                           input logic [31:0] wd, input logic [31:0] rd, input int lat);
        bus_exp_t b;
        b.rwi    = rwi;
        b.addr   = addr;
        b.chk_wd = chk_wd;
        b.wdata  = wd;
        b.rdata  = rd;
        b.lat    = lat;
        bus_q.push_back(b);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rwi"}, {30'd0, ifc.rwi_out}, 32'd3);
        check({tag, "_addr"}, ifc.addr_out, 32'd0);
        check({tag, "_wdata"}, ifc.wdata_out, 32'd0);
        check({tag, "_fetch_instr"}, ifc.fetch_instr, 32'd0);
        check({tag, "_data_rdata"}, ifc.data_rdata, 32'd0);
        check({tag, "_acks_err"}, {29'd0, ifc.fetch_ack, ifc.data_ack, ifc.err}, 32'd0);
    endtask

    task automatic wait_ack(input logic is_data, input string who);
        int t;
        t = 0;
        while (!(is_data ? ifc.data_ack : ifc.fetch_ack) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_ack_wait: no ack after %0d cycles, expected one", who, t);
        end
        last_ack_cyc = cyc;
    endtask

    // Called at a negedge; returns at the negedge after the ack.
    task automatic run_fetch(input logic [31:0] a);
        ifc.fetch_addr = a;
        ifc.fetch_req  = 1'b1;
        wait_ack(1'b0, "fetch");
        ifc.fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        ifc.data_we    = we;
        ifc.data_addr  = a;
        ifc.data_wdata = wd;
        ifc.data_req   = 1'b1;
        wait_ack(1'b1, "data");
        ifc.data_req = 1'b0;
        @(negedge clk);
    endtask

    // Wishbone responder: checks each issued command and answers with busy then data.
    initial begin : bus_model
        bus_exp_t b;
        int cnt;
        cnt = 0;
        ifc.busy_o   = 1'b0;
        ifc.rdata_in = 32'd0;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) ifc.busy_o = 1'b0;
            end else if (ifc.rwi_out != 2'b11 && !bus_dead) begin
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_issue: rwi_out=%b addr_out=0x%08h, none expected",
                             ifc.rwi_out, ifc.addr_out);
                end else begin
                    b = bus_q.pop_front();
                    check("issue_rwi", {30'd0, ifc.rwi_out}, {30'd0, b.rwi});
                    check("issue_addr", ifc.addr_out, b.addr);
                    if (b.chk_wd) check("issue_wdata", ifc.wdata_out, b.wdata);
                    ifc.rdata_in = b.rdata;
                    ifc.busy_o   = 1'b1;
                    cnt          = b.lat;
                end
            end
        end
    end

    // Completion monitor: every ack is matched against the next expected completion.
    initial begin : ack_monitor
        ack_exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.fetch_ack || ifc.data_ack) begin
                check("one_ack_at_a_time", {31'd0, ifc.fetch_ack & ifc.data_ack}, 32'd0);
                check("rwi_idle_at_ack", {30'd0, ifc.rwi_out}, 32'd3);
                if (ack_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_ack: fetch_ack=%0b data_ack=%0b, none expected",
                             ifc.fetch_ack, ifc.data_ack);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_owner_is_data", {31'd0, ifc.data_ack}, {31'd0, e.is_data});
                    check("ack_data", e.is_data ? ifc.data_rdata : ifc.fetch_instr, e.data);
                    check("ack_err", {31'd0, ifc.err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin : stimulus
        int c0;
        ifc.fetch_req  = 1'b0;
        ifc.fetch_addr = 32'd0;
        ifc.data_req   = 1'b0;
        ifc.data_we    = 1'b0;
        ifc.data_addr  = 32'd0;
        ifc.data_wdata = 32'd0;
        #1 nRst = 1'b0;
        #1 check_reset("por");
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        // Lone fetch, two busy cycles.
        exp_bus(2'b10, 32'h3300_0100, 1'b0, 32'd0, 32'hDEAD_BEEF, 2);
        exp_ack(1'b0, 32'hDEAD_BEEF, 1'b0);
        run_fetch(32'h0000_0100);

        // Write: read data returned to the data side must be zero.
        exp_bus(2'b01, 32'h3300_0500, 1'b1, 32'h1234_5678, 32'hA5A5_A5A5, 1);
        exp_ack(1'b1, 32'd0, 1'b0);
        run_data(1'b1, 32'h0000_0500, 32'h1234_5678);
        check("fetch_instr_hold", ifc.fetch_instr, 32'hDEAD_BEEF);

        // Read with upper address byte replaced; operands change during WAIT.
        exp_bus(2'b10, 32'h3300_0600, 1'b0, 32'd0, 32'hCAFE_F00D, 4);
        exp_ack(1'b1, 32'hCAFE_F00D, 1'b0);
        fork
            run_data(1'b0, 32'hAB00_0600, 32'd0);
            begin
                repeat (3) @(negedge clk);
                ifc.data_addr  = 32'h0000_0F00;
                ifc.data_wdata = 32'hFFFF_FFFF;
                ifc.data_we    = 1'b1;
                @(negedge clk);
                check("wait_addr_held", ifc.addr_out, 32'h3300_0600);
                check("wait_wdata_held", ifc.wdata_out, 32'd0);
                check("wait_rwi_idle", {30'd0, ifc.rwi_out}, 32'd3);
            end
        join

        // Busy never asserted: abort with err after the timeout window.
        bus_dead = 1'b1;
        exp_ack(1'b1, 32'd0, 1'b1);
        c0 = cyc;
        run_data(1'b0, 32'h0000_0700, 32'd0);
        check("timeout_latency", last_ack_cyc - c0, 32'd65);
        bus_dead = 1'b0;

        exp_bus(2'b10, 32'h3300_0200, 1'b0, 32'd0, 32'h1111_2222, 1);
        exp_ack(1'b0, 32'h1111_2222, 1'b0);
        run_fetch(32'h0000_0200);

        // Both sides held: D,D,D,D,F,D,D,D,D,F.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                exp_bus(2'b10, 32'h3300_2000, 1'b0, 32'd0, 32'hF00D_0001, 1);
                exp_ack(1'b0, 32'hF00D_0001, 1'b0);
            end
            exp_bus(2'b10, 32'h3300_1000 + 32'(i * 4), 1'b0, 32'd0, 32'hD000_0000 + 32'(i), 1);
            exp_ack(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
        end
        exp_bus(2'b10, 32'h3300_2004, 1'b0, 32'd0, 32'hF00D_0002, 1);
        exp_ack(1'b0, 32'hF00D_0002, 1'b0);
        fork
            begin
                for (int i = 0; i < 8; i++) run_data(1'b0, 32'h0000_1000 + 32'(i * 4), 32'd0);
            end
            begin
                run_fetch(32'h0000_2000);
                run_fetch(32'h0000_2004);
            end
        join

        // Reset while a fetch sits in WAIT: dropped, no ack afterwards.
        exp_bus(2'b10, 32'h3300_0800, 1'b0, 32'd0, 32'h5555_AAAA, 20);
        ifc.fetch_addr = 32'h0000_0800;
        ifc.fetch_req  = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_addr", ifc.addr_out, 32'h3300_0800);
        #2 nRst = 1'b0;
        #1 check_reset("mid_wait");
        ifc.fetch_req = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        repeat (25) @(negedge clk);
        exp_bus(2'b10, 32'h3300_0900, 1'b0, 32'd0, 32'h7777_8888, 1);
        exp_ack(1'b0, 32'h7777_8888, 1'b0);
        run_fetch(32'h0000_0900);

        repeat (3) @(negedge clk);
        check("ack_queue_drained", ack_q.size(), 32'd0);
        check("bus_queue_drained", bus_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/t07_ext_mem_arbiter.md
Name: t07_ext_mem_arbiter

Overview:
- Sequences the single external instruction/data memory port (wishbone manager, `rwi` encoding) between two requesters: CPU instruction fetch and CPU data load/store.
- Sits between the CPU-side fetch/memory handlers and the MMIO decode path that drives the wishbone manager.
- Arbitrates, latches the request, runs the busy handshake, returns data with a one-cycle ack, and aborts hung transactions with a timeout.

Parameters:
- ADDR_PREFIX, 8'h33, upper address byte prepended to addr[23:0] on every issued access
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced
- TIMEOUT, 64, max cycles from issue to completion before abort

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch request, level; held until fetch_ack
- fetch_addr  in  32  instruction address
- fetch_ack  out  1  one-cycle completion pulse to fetch
- fetch_instr  out  32  instruction word; valid when fetch_ack=1
- data_req  in  1  data request, level; held until data_ack
- data_we  in  1  1=write, 0=read
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_ack  out  1  one-cycle completion pulse to data side
- data_rdata  out  32  load data; valid when data_ack=1 and read
- err  out  1  one-cycle pulse with ack when the transaction timed out
- rwi_out  out  2  to wishbone: 10 read, 01 write, 11 idle
- addr_out  out  32  {ADDR_PREFIX, latched_addr[23:0]}
- wdata_out  out  32  latched store data
- busy_o  in  1  wishbone busy
- rdata_in  in  32  wishbone read data

Behaviour:
- Reset (async, nRst=0): state IDLE; rwi_out=11; addr_out, wdata_out, fetch_instr, data_rdata=0; acks and err=0; streak and timeout counters=0; grant owner cleared. Takes effect immediately, including mid-transaction: the transaction is dropped and no ack is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If data_req and fetch_req are both high, grant data unless streak==MAX_DATA_STREAK, in which case grant fetch.
  - A single request is granted directly.
  - On grant, latch owner, addr, we and wdata, clear the timeout counter, and go to ISSUE.
  - With no request, stay in IDLE.
- Streak counter:
  - Increments on a data grant while fetch_req=1.
  - Clears on any fetch grant, or on a data grant while fetch_req=0.
  - Saturates at MAX_DATA_STREAK.
- ISSUE:
  - Drive rwi_out (fetch → 10; data → we ? 01 : 10), plus addr_out and wdata_out.
  - When busy_o=1 is sampled, go to WAIT.
- WAIT:
  - rwi_out=11; addr_out and wdata_out are held.
  - When busy_o=0 is sampled, register rdata_in into the owner's data output and go to DONE.
- DONE:
  - Assert the owner's ack for exactly one cycle (err=0), then go to IDLE.
  - Writes return data_rdata=0.
  - The requester drops req on the edge after ack, so IDLE never re-grants a completed request.
- Timeout: the counter increments every cycle in ISSUE/WAIT. On reaching TIMEOUT-1 without completion:
  - force rwi_out=11;
  - go to DONE with owner ack=1, err=1, data output=0.
- Latency: a grant at edge N gives rwi_out valid at N+1. Minimum issue-to-ack is 3 cycles with busy_o high for one cycle.
- Request inputs are ignored outside IDLE; operand changes after grant have no effect.
- fetch_instr and data_rdata hold their last value between acks.
- Only one ack per cycle; fetch_ack and data_ack are never high together.

Test Plan:
- Reset mid-WAIT (busy_o=1, fetch owner) → outputs at reset values immediately; no fetch_ack after nRst rises; a new fetch_req is granted normally.
- fetch_req alone, fetch_addr=0x0000_0100; wishbone busy 2 cycles, rdata_in=0xDEADBEEF → rwi_out=10 and addr_out=0x3300_0100 one cycle after grant; fetch_ack=1 with fetch_instr=0xDEADBEEF; data_ack stays 0.
- data_req write, data_addr=0x0000_0500, data_wdata=0x12345678 → rwi_out=01, addr_out=0x3300_0500, wdata_out=0x12345678; data_ack=1, data_rdata=0, err=0.
- fetch_req and data_req both held continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,F,D,...; streak resets after the fetch grant.
- Issue with busy_o stuck 0 → abort after TIMEOUT cycles with err=1, owner ack=1, data=0, rwi_out=11; the next request proceeds normally.
- Change data_addr during WAIT → addr_out stays at the latched value; completion ack is unaffected.
